imm_ext_arb: RTL and testbench



---
 rtl/imm_ext_pkg.sv | 18 +
 rtl/imm_ext_core.sv | 29 ++
 rtl/imm_ext_arb.sv | 127 ++++++++++++
 tb/tb_imm_ext_arb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate sign-extension service:
// default widths, requester indices and the captured response layout.
package imm_ext_pkg;

  localparam int IMM_W_DEF = 12;
  localparam int XLEN_DEF  = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic                id;
    logic [XLEN_DEF-1:0] ext;
    logic [XLEN_DEF-1:0] neg;
    logic                ok;
  } rsp_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational sign-extend/negate datapath with two independently built
// extensions so a disagreement between them shows up as ok_o = 0.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic [IMM_W-1:0] imm_i,
  output logic [XLEN-1:0]  ext_a_o,
  output logic [XLEN-1:0]  ext_b_o,
  output logic [XLEN-1:0]  neg_o,
  output logic             ok_o
);

  logic signed [XLEN-1:0] shl_s;
  logic        [XLEN-1:0] sum_s;

  assign ext_a_o = {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};

  // Park the immediate at the top and shift it back down arithmetically.
  assign shl_s   = {imm_i, {(XLEN-IMM_W){1'b0}}};
  assign ext_b_o = shl_s >>> (XLEN-IMM_W);

  assign neg_o   = ~ext_a_o + {{(XLEN-1){1'b0}}, 1'b1};
  assign sum_s   = ext_a_o + neg_o;
  assign ok_o    = (ext_a_o == ext_b_o) && (sum_s == {XLEN{1'b0}});

endmodule

// File: rtl/imm_ext_arb.sv
// Two-requester round-robin front end for one shared sign-extension unit,
// with a one-entry response register and a saturating self-check counter.
module imm_ext_arb
  import imm_ext_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [IMM_W-1:0] req0_imm,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IMM_W-1:0] req1_imm,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [XLEN-1:0]  rsp_ext,
  output logic [XLEN-1:0]  rsp_neg,
  output logic             rsp_ok,
  output logic [ERR_W-1:0] err_cnt
);

  logic             accept_s;
  logic             grant_vld_s;
  logic             grant_id_s;
  logic [IMM_W-1:0] imm_sel_s;
  logic [XLEN-1:0]  ext_a_s;
  logic [XLEN-1:0]  ext_b_s;
  logic [XLEN-1:0]  neg_s;
  logic             ok_s;

  rsp_t             rsp_q, rsp_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             last_q, last_d;
  logic [ERR_W-1:0] err_q, err_d;

  assign accept_s = !rsp_valid_q || rsp_ready;

  // Round-robin grant: on contention the requester that did not win last time goes.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = REQ0;
    if (rst_n && accept_s) begin
      if (req0_valid && req1_valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = (last_q == REQ0) ? REQ1 : REQ0;
      end else if (req0_valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = REQ0;
      end else if (req1_valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = REQ1;
      end else begin
        grant_vld_s = 1'b0;
      end
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  assign req0_ready = grant_vld_s && (grant_id_s == REQ0);
  assign req1_ready = grant_vld_s && (grant_id_s == REQ1);
  assign imm_sel_s  = (grant_id_s == REQ1) ? req1_imm : req0_imm;

  imm_ext_core #(
    .IMM_W (IMM_W),
    .XLEN  (XLEN)
  ) u_core (
    .imm_i   (imm_sel_s),
    .ext_a_o (ext_a_s),
    .ext_b_o (ext_b_s),
    .neg_o   (neg_s),
    .ok_o    (ok_s)
  );

  // Response register, round-robin pointer and error counter next state.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    last_d      = last_q;
    err_d       = err_q;
    if (grant_vld_s) begin
      rsp_valid_d = 1'b1;
      rsp_d.id    = grant_id_s;
      rsp_d.ext   = ext_a_s;
      rsp_d.neg   = neg_s;
      rsp_d.ok    = ok_s;
      last_d      = grant_id_s;
      if (!ok_s && (err_q != {ERR_W{1'b1}})) begin
        err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end else begin
        err_d = err_q;
      end
    end else if (accept_s) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      last_q      <= REQ1;
      err_q       <= {ERR_W{1'b0}};
    end else begin
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_ext   = rsp_q.ext;
  assign rsp_neg   = rsp_q.neg;
  assign rsp_ok    = rsp_q.ok;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_imm_ext_arb.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_imm_ext_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [11:0] req0_imm, req1_imm;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ok;
  logic [31:0] rsp_ext, rsp_neg;
  logic [7:0]  err_cnt;

  int n_pass  = 0;
  int n_total = 0;

  imm_ext_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_imm   (req0_imm),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_imm   (req1_imm),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_ext    (rsp_ext),
    .rsp_neg    (rsp_neg),
    .rsp_ok     (rsp_ok),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [31:0] sext(input logic [11:0] v);
    logic signed [31:0] t;
    t = $signed(v);
    return t;
  endfunction

  // Behavioural model: the held response, who won last, and whether the
  // data registers are still in their post-reset state.
  logic        m_valid, m_id, m_last, m_zero;
  logic [31:0] m_ext, m_neg;
  logic        m_acc, m_gv, m_gid, e_r0, e_r1;

  always_comb begin
    m_acc = !m_valid || rsp_ready;
    m_gv  = rst_n && m_acc && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) m_gid = !m_last;
    else m_gid = req1_valid;
    e_r0 = m_gv && !m_gid;
    e_r1 = m_gv && m_gid;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_last  <= 1'b1;
      m_zero  <= 1'b1;
    end else if (m_gv) begin
      m_valid <= 1'b1;
      m_id    <= m_gid;
      m_ext   <= sext(m_gid ? req1_imm : req0_imm);
      m_neg   <= 32'd0 - sext(m_gid ? req1_imm : req0_imm);
      m_last  <= m_gid;
      m_zero  <= 1'b0;
    end else if (m_acc) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if ($time > 0) begin
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      chk("err_cnt", {24'd0, err_cnt}, 32'd0);
      if (m_valid) begin
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
        chk("rsp_ext", rsp_ext, m_ext);
        chk("rsp_neg", rsp_neg, m_neg);
        chk("rsp_ok", {31'd0, rsp_ok}, 32'd1);
      end else if (m_zero) begin
        chk("rst_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_ext", rsp_ext, 32'd0);
        chk("rst_neg", rsp_neg, 32'd0);
        chk("rst_ok", {31'd0, rsp_ok}, 32'd0);
      end
    end
  end

  task automatic step(input logic rst, input logic v0, input logic [11:0] i0,
                      input logic v1, input logic [11:0] i1, input logic rr);
    @(posedge clk);
    #1;
    rst_n = rst; req0_valid = v0; req0_imm = i0;
    req1_valid = v1; req1_imm = i1; rsp_ready = rr;
    @(negedge clk);
  endtask

  logic [11:0] b_imm [5] = '{12'h000, 12'h7FF, 12'h800, 12'hFFF, 12'd1337};
  logic [31:0] b_ext [5] = '{32'h00000000, 32'h000007FF, 32'hFFFFF800, 32'hFFFFFFFF, 32'h00000539};
  logic [31:0] b_neg [5] = '{32'h00000000, 32'hFFFFF801, 32'h00000800, 32'h00000001, 32'hFFFFFAC7};

  initial begin
    logic p0, p1;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_imm = 12'd0; req1_imm = 12'd0; rsp_ready = 1'b1;

    // Reset holds readies low even with a valid request.
    step(1'b0, 1'b1, 12'd5, 1'b0, 12'd0, 1'b1);
    chk("lit_rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("lit_rst_valid", {31'd0, rsp_valid}, 32'd0);

    // Single request, one-cycle latency.
    step(1'b1, 1'b1, 12'd5, 1'b0, 12'd0, 1'b1);
    chk("lit_single_ready", {31'd0, req0_ready}, 32'd1);
    step(1'b1, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
    chk("lit_single_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lit_single_ext", rsp_ext, 32'h00000005);
    chk("lit_single_neg", rsp_neg, 32'hFFFFFFFB);
    chk("lit_model_neg5", m_neg, 32'hFFFFFFFB);

    // Contention after reset alternates starting with requester 0.
    step(1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 12'd12, 1'b1, 12'hFFB, 1'b1);
      chk("lit_alt_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) chk("lit_alt_ext", rsp_ext, (k % 2 == 1) ? 32'h0000000C : 32'hFFFFFFFB);
    end
    step(1'b1, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
    chk("lit_alt_last_id", {31'd0, rsp_id}, 32'd1);

    // Stall for three cycles, then release to the other requester.
    step(1'b1, 1'b1, 12'd77, 1'b0, 12'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 12'd78, 1'b1, 12'd79, 1'b0);
      chk("lit_stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("lit_stall_ext", rsp_ext, 32'd77);
    end
    step(1'b1, 1'b1, 12'd78, 1'b1, 12'd79, 1'b1);
    chk("lit_release_ready1", {31'd0, req1_ready}, 32'd1);

    // Drain and refill in the same cycle.
    step(1'b1, 1'b0, 12'd0, 1'b1, 12'h81D, 1'b1);
    chk("lit_refill_ready1", {31'd0, req1_ready}, 32'd1);
    step(1'b1, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
    chk("lit_refill_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lit_refill_ext", rsp_ext, 32'hFFFFF81D);
    chk("lit_refill_neg", rsp_neg, 32'h000007E3);

    // Boundary immediates back to back.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, k < 5, (k < 5) ? b_imm[k] : 12'd0, 1'b0, 12'd0, 1'b1);
      if (k > 0) begin
        chk("lit_bnd_ext", rsp_ext, b_ext[k-1]);
        chk("lit_bnd_neg", rsp_neg, b_neg[k-1]);
        chk("lit_bnd_ok", {31'd0, rsp_ok}, 32'd1);
      end
    end
    chk("lit_bnd_err", {24'd0, err_cnt}, 32'd0);

    // Reset in the middle of a stall.
    step(1'b1, 1'b1, 12'd1, 1'b0, 12'd0, 1'b1);
    step(1'b1, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
    step(1'b0, 1'b1, 12'd2, 1'b1, 12'd3, 1'b0);
    chk("lit_rst_stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    step(1'b1, 1'b1, 12'd2, 1'b1, 12'd3, 1'b1);
    chk("lit_rst_stall_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lit_rst_stall_err", {24'd0, err_cnt}, 32'd0);
    chk("lit_rst_stall_grant0", {31'd0, req0_ready}, 32'd1);

    // Randomized traffic honouring hold-until-ready.
    p0 = 1'b0; p1 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 99) != 0);
      if (!p0) begin req0_valid = 1'($urandom_range(0, 1)); req0_imm = 12'($urandom); end
      if (!p1) begin req1_valid = 1'($urandom_range(0, 1)); req1_imm = 12'($urandom); end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      p0 = req0_valid && !req0_ready;
      p1 = req1_valid && !req1_ready;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
